// File: rtl/rf_write_arbiter_if.sv
// Handshake bundle between the WB stage, the long-latency unit and the
// register-file write port.
interface rf_write_arbiter_if #(
   parameter int XLEN = 32
);
   logic            wb_valid;
   logic [4:0]      wb_rd;
   logic [XLEN-1:0] wb_data;
   logic            wb_stall;
   logic            lu_valid;
   logic [4:0]      lu_rd;
   logic [XLEN-1:0] lu_data;
   logic            lu_ready;
   logic            rf_write_en;
   logic [4:0]      rf_rd_addr;
   logic [XLEN-1:0] rf_rd_data;

   modport master (
      output wb_valid, wb_rd, wb_data, lu_valid, lu_rd, lu_data,
      input  wb_stall, lu_ready, rf_write_en, rf_rd_addr, rf_rd_data
   );

   modport slave (
      input  wb_valid, wb_rd, wb_data, lu_valid, lu_rd, lu_data,
      output wb_stall, lu_ready, rf_write_en, rf_rd_addr, rf_rd_data
   );
endinterface

// File: rtl/rf_write_arbiter.sv
// Shares one register-file write port between writeback and the long-latency unit,
// with starvation protection for the LU. Define RF_ARB_PERF_CNT_EN for conflict_cnt.
module rf_write_arbiter #(
   parameter int XLEN       = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
`ifdef RF_ARB_PERF_CNT_EN
   output logic [31:0]          conflict_cnt,
`endif
   rf_write_arbiter_if.slave    bus
);

   typedef enum logic {NORMAL, FORCE} state_t;

   state_t          state_q, state_d;
   logic [3:0]      starve_q, starve_d;
   logic            wb_live, lu_live, conflict;
   logic            wb_stall, lu_ready;
   logic            gnt_wb, gnt_lu;
   logic            we_q;
   logic [4:0]      addr_q;
   logic [XLEN-1:0] data_q;

   assign wb_live  = bus.wb_valid && (bus.wb_rd != 5'd0);
   assign lu_live  = bus.lu_valid && (bus.lu_rd != 5'd0);
   assign conflict = wb_live && lu_live;

   always_comb begin
      state_d  = state_q;
      starve_d = starve_q;
      wb_stall = 1'b0;
      lu_ready = 1'b0;
      gnt_wb   = 1'b0;
      gnt_lu   = 1'b0;
      case (state_q)
         NORMAL: begin
            // rd=0 requests never need the port, so they are never held off
            lu_ready = bus.lu_valid && !conflict;
            gnt_wb   = wb_live;
            gnt_lu   = lu_live && !wb_live;
            if (lu_ready)
               starve_d = 4'd0;
            else if (conflict && starve_q != 4'hF)
               starve_d = starve_q + 4'd1;
            if (starve_d == 4'(STARVE_MAX))
               state_d = FORCE;
         end
         FORCE: begin
            if (bus.lu_valid) begin
               lu_ready = 1'b1;
               gnt_lu   = lu_live;
               wb_stall = conflict;
               gnt_wb   = wb_live && !lu_live;
            end else begin
               gnt_wb = wb_live;
            end
            state_d  = NORMAL;
            starve_d = 4'd0;
         end
         default: begin
            state_d  = NORMAL;
            starve_d = 4'd0;
         end
      endcase
      if (!rst_n) begin
         wb_stall = 1'b0;
         lu_ready = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= NORMAL;
         starve_q <= 4'd0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
      end
   end

   // Write port stage: address/data hold their last value when idle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q   <= 1'b0;
         addr_q <= 5'd0;
         data_q <= '0;
      end else begin
         we_q <= gnt_wb || gnt_lu;
         if (gnt_wb) begin
            addr_q <= bus.wb_rd;
            data_q <= bus.wb_data;
         end else if (gnt_lu) begin
            addr_q <= bus.lu_rd;
            data_q <= bus.lu_data;
         end
      end
   end

   assign bus.wb_stall    = wb_stall;
   assign bus.lu_ready    = lu_ready;
   assign bus.rf_write_en = we_q;
   assign bus.rf_rd_addr  = addr_q;
   assign bus.rf_rd_data  = data_q;

`ifdef RF_ARB_PERF_CNT_EN
   logic [31:0] conflict_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         conflict_cnt_q <= 32'd0;
      else
         conflict_cnt_q <= conflict_cnt_q + 32'(conflict);
   end

   assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: vector table plus hand-written
// starvation, force-drop, same-rd and reset sequences; writes checked via a queue.
module tb_rf_write_arbiter;
   localparam int XLEN = 32;
   localparam int SMAX = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   rf_write_arbiter_if #(.XLEN(XLEN)) bus();
`ifdef RF_ARB_PERF_CNT_EN
   logic [31:0] conflict_cnt;
`endif

   rf_write_arbiter #(.XLEN(XLEN), .STARVE_MAX(SMAX)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
`ifdef RF_ARB_PERF_CNT_EN
      .conflict_cnt (conflict_cnt),
`endif
      .bus          (bus)
   );

   typedef struct {
      logic        wv; logic [4:0] wrd; logic [31:0] wd;
      logic        lv; logic [4:0] lrd; logic [31:0] ld;
      logic        es; logic er; logic ewe; logic [4:0] ea; logic [31:0] ed;
      string       nm;
   } vec_t;

   typedef struct {
      logic we; logic [4:0] a; logic [31:0] d; string nm;
   } wr_t;

   wr_t         sbq[$];
   int          pass_cnt = 0;
   int          total_cnt = 0;
   logic [4:0]  last_a = 5'd0;
   logic [31:0] last_d = 32'd0;
   vec_t        tbl[7];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h, expected %h", nm, act, exp);
   endtask

   task automatic drive(input logic wv, input logic [4:0] wrd, input logic [31:0] wd,
                        input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
      bus.wb_valid = wv; bus.wb_rd = wrd; bus.wb_data = wd;
      bus.lu_valid = lv; bus.lu_rd = lrd; bus.lu_data = ld;
   endtask

   // Called just after a rising edge: drive, check handshake, then check the write one edge later.
   task automatic step(input vec_t v);
      wr_t e, g;
      drive(v.wv, v.wrd, v.wd, v.lv, v.lrd, v.ld);
      #1;
      chk({v.nm, ".wb_stall"}, 32'(bus.wb_stall), 32'(v.es));
      chk({v.nm, ".lu_ready"}, 32'(bus.lu_ready), 32'(v.er));
      if (v.ewe) begin last_a = v.ea; last_d = v.ed; end
      e.we = v.ewe; e.a = last_a; e.d = last_d; e.nm = v.nm;
      sbq.push_back(e);
      @(posedge clk); #1;
      if (sbq.size() == 0) begin
         chk("scoreboard_empty", 32'd1, 32'd0);
      end else begin
         g = sbq.pop_front();
         chk({g.nm, ".rf_write_en"}, 32'(bus.rf_write_en), 32'(g.we));
         chk({g.nm, ".rf_rd_addr"},  32'(bus.rf_rd_addr),  32'(g.a));
         chk({g.nm, ".rf_rd_data"},  bus.rf_rd_data,       g.d);
      end
   endtask

   function automatic vec_t mk(input logic wv, input logic [4:0] wrd, input logic [31:0] wd,
                               input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                               input logic es, input logic er, input logic ewe,
                               input logic [4:0] ea, input logic [31:0] ed, input string nm);
      vec_t v;
      v.wv = wv; v.wrd = wrd; v.wd = wd; v.lv = lv; v.lrd = lrd; v.ld = ld;
      v.es = es; v.er = er; v.ewe = ewe; v.ea = ea; v.ed = ed; v.nm = nm;
      return v;
   endfunction

   initial begin
      tbl[0] = mk(1,  5, 32'hDEADBEEF, 0,  0, 32'h0,   0, 0, 1,  5, 32'hDEADBEEF, "wb_only");
      tbl[1] = mk(0,  0, 32'h0,        0,  0, 32'h0,   0, 0, 0,  0, 32'h0,        "idle_hold");
      tbl[2] = mk(1,  0, 32'h11111111, 1,  7, 32'h77,  0, 1, 1,  7, 32'h77,       "wb_rd0_lu7");
      tbl[3] = mk(0,  0, 32'h0,        1,  9, 32'h99,  0, 1, 1,  9, 32'h99,       "lu_only");
      tbl[4] = mk(1,  0, 32'h55,       0,  0, 32'h0,   0, 0, 0,  0, 32'h0,        "wb_rd0_only");
      tbl[5] = mk(0,  0, 32'h0,        1,  0, 32'h66,  0, 1, 0,  0, 32'h0,        "lu_rd0_only");
      tbl[6] = mk(1, 31, 32'hFFFFFFFF, 1,  0, 32'h1,   0, 1, 1, 31, 32'hFFFFFFFF, "wb31_lu_rd0");

      // Reset state with requests present
      drive(1, 3, 32'h33, 1, 4, 32'h44);
      #12;
      chk("rst.wb_stall",    32'(bus.wb_stall),    32'd0);
      chk("rst.lu_ready",    32'(bus.lu_ready),    32'd0);
      chk("rst.rf_write_en", 32'(bus.rf_write_en), 32'd0);
      chk("rst.rf_rd_addr",  32'(bus.rf_rd_addr),  32'd0);
      chk("rst.rf_rd_data",  bus.rf_rd_data,       32'd0);
      drive(0, 0, 0, 0, 0, 0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 7; i++) step(tbl[i]);

      // LU starves for SMAX conflict cycles, then wins once
      for (int i = 1; i <= SMAX; i++)
         step(mk(1, 5'(i), 32'h100 + i, 1, 12, 32'hC0FFEE, 0, 0, 1, 5'(i), 32'h100 + i, "starve_wb"));
      step(mk(1, 5, 32'h105, 1, 12, 32'hC0FFEE, 1, 1, 1, 12, 32'hC0FFEE, "force_lu"));
      step(mk(1, 5, 32'h105, 0, 0, 32'h0,       0, 0, 1,  5, 32'h105,    "wb_after_force"));

      // Enter FORCE, then LU withdraws: no stall, counter back to zero
      for (int i = 1; i <= SMAX; i++)
         step(mk(1, 5'(16 + i), 32'h200 + i, 1, 13, 32'hD00D, 0, 0, 1, 5'(16 + i), 32'h200 + i, "starve2_wb"));
      step(mk(1, 6, 32'h600, 0, 0, 32'h0, 0, 0, 1, 6, 32'h600, "force_drop"));
      for (int i = 0; i < SMAX; i++)
         step(mk(1, 5'(20 + i), 32'h300 + i, 1, 14, 32'hE0, 0, 0, 1, 5'(20 + i), 32'h300 + i, "recount_wb"));
      step(mk(1, 25, 32'h325, 1, 14, 32'hE0, 1, 1, 1, 14, 32'hE0, "force_again"));

      // Same rd: WB written first, LU overwrites a cycle later
      step(mk(1, 8, 32'hAAAA, 1, 8, 32'hBBBB, 0, 0, 1, 8, 32'hAAAA, "same_rd_wb"));
      step(mk(0, 0, 32'h0,    1, 8, 32'hBBBB, 0, 1, 1, 8, 32'hBBBB, "same_rd_lu"));

      // Reset mid-conflict while a write is on the port
      drive(1, 10, 32'hA0, 1, 11, 32'hB0);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst.wb_stall",    32'(bus.wb_stall),    32'd0);
      chk("midrst.lu_ready",    32'(bus.lu_ready),    32'd0);
      chk("midrst.rf_write_en", 32'(bus.rf_write_en), 32'd0);
      chk("midrst.rf_rd_addr",  32'(bus.rf_rd_addr),  32'd0);
      chk("midrst.rf_rd_data",  bus.rf_rd_data,       32'd0);
      drive(0, 0, 0, 0, 0, 0);
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         chk("post_rst.rf_write_en", 32'(bus.rf_write_en), 32'd0);
      end
      last_a = 5'd0; last_d = 32'd0;

`ifdef RF_ARB_PERF_CNT_EN
      chk("perf.after_reset", conflict_cnt, 32'd0);
      drive(1, 2, 32'h2, 1, 3, 32'h3);
      repeat (6) @(posedge clk);
      #1;
      drive(0, 0, 0, 0, 0, 0);
      chk("perf.six_conflicts", conflict_cnt, 32'd6);
      @(posedge clk); #1;
      chk("perf.hold", conflict_cnt, 32'd6);
`endif

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, passed %0d of %0d", pass_cnt, total_cnt);
      $fatal(1);
   end
endmodule
